// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access unit.
// FSM states, funct3 encodings and the registered bus command.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [1:0]  lane;
  } bus_cmd_t;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (f3)
        SB, SH, SW: ok = 1'b1;
        default:    ok = 1'b0;
      endcase
    end else begin
      case (f3)
        LB, LH, LW, LBU, LHU: ok = 1'b1;
        default:              ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic half_bad;
    logic word_bad;
    half_bad = (f3[1:0] == 2'b01) && a[0];
    word_bad = (f3[1:0] == 2'b10) && (a != 2'b00);
    return half_bad || word_bad;
  endfunction

endpackage

// File: rtl/dmem_access_unit_load_align.sv
// Load lane select and sign/zero extension of a raw bus word.
// Purely combinational; illegal funct3 yields zero.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      data = {{24{b[7]}}, b};
      LH:      data = {{16{h[15]}}, h};
      LW:      data = word;
      LBU:     data = {24'h0, b};
      LHU:     data = {16'h0, h};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data memory access unit: request decode, bus FSM,
// store lane/byte-enable generation and timeout fault detection.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT_CYCLES);

  state_e         state_q, state_d;
  bus_cmd_t       cmd_q, cmd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cnt_inc;
  logic [31:0]    data_q, data_d;
  logic           tmo_q, tmo_d;

  logic           req_any;
  logic           conflict;
  logic           legal;
  logic           aligned;
  logic           valid;
  logic           bad;
  bus_cmd_t       new_cmd;
  logic [31:0]    ld_data;

  load_align u_load_align (
    .word   (bus_rdata),
    .lane   (cmd_q.lane),
    .funct3 (cmd_q.funct3),
    .data   (ld_data)
  );

  always_comb begin
    req_any  = mem_read | mem_write;
    conflict = mem_read & mem_write;
    legal    = f3_legal(mem_write, funct3);
    aligned  = !misaligned(funct3, addr[1:0]);
    valid    = req_any && !conflict && legal && aligned;
    bad      = req_any && !valid;
  end

  always_comb begin
    new_cmd        = '0;
    new_cmd.addr   = {addr[31:2], 2'b00};
    new_cmd.we     = mem_write;
    new_cmd.funct3 = funct3;
    new_cmd.lane   = addr[1:0];
    new_cmd.be     = 4'b1111;
    if (mem_write) begin
      case (funct3)
        SB: begin
          new_cmd.be    = 4'b0001 << addr[1:0];
          new_cmd.wdata = {4{wdata[7:0]}};
        end
        SH: begin
          new_cmd.be    = addr[1] ? 4'b1100 : 4'b0011;
          new_cmd.wdata = {2{wdata[15:0]}};
        end
        default: begin
          new_cmd.be    = 4'b1111;
          new_cmd.wdata = wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    cnt_inc   = cnt_q + CW'(1);
    rdata     = 32'h0;
    stall     = 1'b0;
    fault     = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    bus_be    = 4'b0000;
    case (state_q)
      S_IDLE: begin
        tmo_d  = 1'b0;
        data_d = 32'h0;
        if (valid) begin
          state_d = S_BUSY;
          cmd_d   = new_cmd;
          cnt_d   = '0;
          stall   = 1'b1;
        end else if (bad) begin
          fault = 1'b1;
        end
      end
      S_BUSY: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = cmd_q.we;
        bus_addr  = cmd_q.addr;
        bus_wdata = cmd_q.wdata;
        bus_be    = cmd_q.be;
        if (bus_ack) begin
          state_d = S_DONE;
          data_d  = cmd_q.we ? 32'h0 : ld_data;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
          data_d  = 32'h0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        rdata   = data_q;
        fault   = tmo_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset also silences the outputs in the cycle it is seen.
    if (reset) begin
      rdata     = 32'h0;
      stall     = 1'b0;
      fault     = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 32'h0;
      bus_wdata = 32'h0;
      bus_be    = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 32'h0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: loads, stores, faults,
// timeout and reset during a bus transfer.
module tb_dmem_access_unit;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int total;
  int bad;

  dmem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
  endtask

  task automatic do_load(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] word,
    input logic [31:0] exp
  );
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    tick();
    mem_read = 1'b1;
    funct3   = f3;
    addr     = a;
    #1;
    chk({tag, ".stall_n"}, stall, 1);
    chk({tag, ".req_n"}, bus_req, 0);
    tick();
    bus_ack   = 1'b1;
    bus_rdata = word;
    #1;
    chk({tag, ".req_n1"}, bus_req, 1);
    chk({tag, ".stall_n1"}, stall, 1);
    chk({tag, ".addr"}, bus_addr, wa);
    chk({tag, ".be"}, bus_be, 4'hF);
    chk({tag, ".we"}, bus_we, 0);
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h5A5A5A5A;
    #1;
    chk({tag, ".rdata"}, rdata, exp);
    chk({tag, ".stall_n2"}, stall, 0);
    chk({tag, ".req_n2"}, bus_req, 0);
    chk({tag, ".fault"}, fault, 0);
    tick();
    idle_in();
    #1;
    chk({tag, ".rdata_idle"}, rdata, 0);
  endtask

  task automatic do_store(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] ea,
    input logic [3:0]  ebe,
    input logic [31:0] ewd
  );
    tick();
    mem_write = 1'b1;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1;
    chk({tag, ".stall_n"}, stall, 1);
    tick();
    addr  = 32'h0;
    wdata = 32'hFFFFFFFF;
    #1;
    chk({tag, ".req"}, bus_req, 1);
    chk({tag, ".we"}, bus_we, 1);
    chk({tag, ".addr"}, bus_addr, ea);
    chk({tag, ".be"}, {28'h0, bus_be}, {28'h0, ebe});
    chk({tag, ".wdata"}, bus_wdata, ewd);
    tick();
    bus_ack = 1'b1;
    #1;
    chk({tag, ".addr_hold"}, bus_addr, ea);
    chk({tag, ".wdata_hold"}, bus_wdata, ewd);
    tick();
    bus_ack = 1'b0;
    #1;
    chk({tag, ".rdata"}, rdata, 0);
    chk({tag, ".stall_done"}, stall, 0);
    chk({tag, ".req_done"}, bus_req, 0);
    tick();
    idle_in();
  endtask

  task automatic do_bad(
    input string       tag,
    input logic        rd,
    input logic        wr,
    input logic [2:0]  f3,
    input logic [31:0] a
  );
    tick();
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = 32'h12345678;
    #1;
    chk({tag, ".fault"}, fault, 1);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".req"}, bus_req, 0);
    chk({tag, ".rdata"}, rdata, 0);
    tick();
    idle_in();
    #1;
    chk({tag, ".fault_gone"}, fault, 0);
    chk({tag, ".req_after"}, bus_req, 0);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    idle_in();
    reset     = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    bus_ack   = 1'b1;
    tick();
    tick();
    #1;
    chk("rst.fault", fault, 0);
    chk("rst.stall", stall, 0);
    chk("rst.req", bus_req, 0);
    reset = 1'b0;
    idle_in();
    bus_ack = 1'b1;
    tick();
    #1;
    chk("idle.rdata", rdata, 0);
    chk("idle.stall", stall, 0);
    chk("idle.req", bus_req, 0);
    chk("idle.be", {28'h0, bus_be}, 0);
    chk("idle.addr", bus_addr, 0);
    bus_ack = 1'b0;

    do_load("lw100", 3'b010, 32'h100, 32'hDEADBEEF,
            32'hDEADBEEF);
    do_load("lb103", 3'b000, 32'h103, 32'h80123456,
            32'hFFFFFF80);
    do_load("lbu103", 3'b100, 32'h103, 32'h80123456,
            32'h00000080);
    do_load("lh102", 3'b001, 32'h102, 32'h80123456,
            32'hFFFF8012);
    do_load("lhu102", 3'b101, 32'h102, 32'h80123456,
            32'h00008012);
    do_load("lb100", 3'b000, 32'h100, 32'h80123456,
            32'h00000056);
    do_load("lb101", 3'b000, 32'h101, 32'h80123456,
            32'h00000034);
    do_load("lh100", 3'b001, 32'h100, 32'h80123456,
            32'h00003456);

    do_store("sh202", 3'b001, 32'h202, 32'h0000ABCD,
             32'h200, 4'b1100, 32'hABCDABCD);
    do_store("sh010", 3'b001, 32'h010, 32'hFFFF9876,
             32'h010, 4'b0011, 32'h98769876);
    do_store("sb105", 3'b000, 32'h105, 32'h12345677,
             32'h104, 4'b0010, 32'h77777777);
    do_store("sb003", 3'b000, 32'h003, 32'h000000AA,
             32'h000, 4'b1000, 32'hAAAAAAAA);
    do_store("sw300", 3'b010, 32'h300, 32'hCAFEF00D,
             32'h300, 4'b1111, 32'hCAFEF00D);

    do_bad("lw101", 1'b1, 1'b0, 3'b010, 32'h101);
    do_bad("lh103", 1'b1, 1'b0, 3'b001, 32'h103);
    do_bad("sh201", 1'b0, 1'b1, 3'b001, 32'h201);
    do_bad("ld011", 1'b1, 1'b0, 3'b011, 32'h100);
    do_bad("ld110", 1'b1, 1'b0, 3'b110, 32'h100);
    do_bad("st011", 1'b0, 1'b1, 3'b011, 32'h100);
    do_bad("st100", 1'b0, 1'b1, 3'b100, 32'h100);
    do_bad("rdwr", 1'b1, 1'b1, 3'b010, 32'h100);

    tick();
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h400;
    #1;
    chk("tmo.stall_n", stall, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus_req) break;
      n++;
    end
    chk("tmo.req_cycles", n, 16);
    chk("tmo.fault", fault, 1);
    chk("tmo.rdata", rdata, 0);
    chk("tmo.stall", stall, 0);
    tick();
    idle_in();
    #1;
    chk("tmo.fault_gone", fault, 0);
    chk("tmo.req_idle", bus_req, 0);

    tick();
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h500;
    tick();
    #1;
    chk("rb.busy1", bus_req, 1);
    tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    idle_in();
    bus_ack   = 1'b1;
    bus_rdata = 32'h11111111;
    #1;
    chk("rb.req", bus_req, 0);
    chk("rb.stall", stall, 0);
    chk("rb.fault", fault, 0);
    chk("rb.rdata", rdata, 0);
    tick();
    bus_ack = 1'b0;
    #1;
    chk("rb.rdata2", rdata, 0);
    chk("rb.fault2", fault, 0);
    chk("rb.stall2", stall, 0);
    do_load("lw_after_rst", 3'b010, 32'h504, 32'h0BADF00D,
            32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
